// File: rtl/spi_master_mcs_pkg.sv
// Shared SPI master definitions: FSM state encoding, mode bit positions and
// the chip-select index width helper.
package spi_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_LEAD, ST_SHIFT, ST_TRAIL} spi_state_e;

  localparam int MODE_W   = 2;
  localparam int CPOL_IDX = 1;
  localparam int CPHA_IDX = 0;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/spi_master_mcs_clk_gen.sv
// SCK divider: counts CLK_DIV cycles per half-period and flags leading and
// trailing SCK edges while the shift phase is running.
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic cpol_i,
  input  logic active_i,
  input  logic run_i,
  output logic tick_o,
  output logic lead_o,
  output logic trail_o,
  output logic sck_o
);
  localparam int CW = $clog2(CLK_DIV + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sck_q, sck_d;
  logic          cpol_q, cpol_d;

  assign tick_o  = active_i && (cnt_q == '0);
  assign lead_o  = run_i && tick_o && (sck_q == cpol_q);
  assign trail_o = run_i && tick_o && (sck_q != cpol_q);
  assign sck_o   = sck_q;

  // The first period after a load is one cycle longer so that the lead-in
  // phase starts the cycle after the request is taken.
  always_comb begin
    cnt_d  = cnt_q;
    sck_d  = sck_q;
    cpol_d = cpol_q;
    if (load_i) begin
      cnt_d  = CW'(CLK_DIV);
      sck_d  = cpol_i;
      cpol_d = cpol_i;
    end else if (active_i) begin
      cnt_d = tick_o ? CW'(CLK_DIV - 1) : cnt_q - 1'b1;
      if (run_i && tick_o) sck_d = ~sck_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      sck_q  <= 1'b0;
      cpol_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sck_q  <= sck_d;
      cpol_q <= cpol_d;
    end
  end
endmodule

// File: rtl/spi_master_mcs.sv
// SPI master with NUM_SLAVES one-hot chip selects; runs one MSB-first frame
// per accepted start in any of the four SPI modes.
module spi_master_mcs
  import spi_pkg::*;
#(
  parameter int  DATA_LENGTH = 8,
  parameter int  NUM_SLAVES  = 4,
  parameter int  CLK_DIV     = 4,
  localparam int SW          = sel_width(NUM_SLAVES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [SW-1:0]          slave_sel,
  input  logic [MODE_W-1:0]      mode,
  input  logic [DATA_LENGTH-1:0] tx_data,
  input  logic                   MISO,
  output logic                   SCK,
  output logic                   MOSI,
  output logic [NUM_SLAVES-1:0]  SS_n,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [DATA_LENGTH-1:0] rx_data
);
  localparam int            EW        = $clog2(2 * DATA_LENGTH);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_LENGTH - 1);

  spi_state_e             state_q;
  logic                   busy_q, done_q, err_q, mosi_q, cpha_q;
  logic [NUM_SLAVES-1:0]  ss_n_q;
  logic [DATA_LENGTH-1:0] tx_sh_q, rx_sh_q, rx_data_q;
  logic [EW-1:0]          edge_cnt_q;

  logic sel_ok, accept, reject, last_edge, advance, sample;
  logic tick, lead, trail;

  // CPHA=1 already drives the MSB before the first leading edge, so that
  // edge does not advance MOSI; CPHA=0 must not advance past the last bit.
  always_comb begin
    sel_ok    = int'(slave_sel) < NUM_SLAVES;
    accept    = (state_q == ST_IDLE) && start && sel_ok;
    reject    = (state_q == ST_IDLE) && start && !sel_ok;
    last_edge = (edge_cnt_q == LAST_EDGE);
    advance   = cpha_q ? (lead && (edge_cnt_q != '0)) : (trail && !last_edge);
    sample    = cpha_q ? trail : lead;
  end

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk      (clk),
    .rst      (rst),
    .load_i   (accept),
    .cpol_i   (mode[CPOL_IDX]),
    .active_i (busy_q),
    .run_i    (state_q == ST_SHIFT),
    .tick_o   (tick),
    .lead_o   (lead),
    .trail_o  (trail),
    .sck_o    (SCK)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ss_n_q     <= '1;
      mosi_q     <= 1'b0;
      cpha_q     <= 1'b0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      edge_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= reject;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q    <= ST_LEAD;
            busy_q     <= 1'b1;
            ss_n_q     <= ~(NUM_SLAVES'(1) << slave_sel);
            cpha_q     <= mode[CPHA_IDX];
            mosi_q     <= tx_data[DATA_LENGTH-1];
            tx_sh_q    <= {tx_data[DATA_LENGTH-2:0], 1'b0};
            edge_cnt_q <= '0;
          end
        end
        ST_LEAD: begin
          if (tick) state_q <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (tick) begin
            if (advance) begin
              mosi_q  <= tx_sh_q[DATA_LENGTH-1];
              tx_sh_q <= {tx_sh_q[DATA_LENGTH-2:0], 1'b0};
            end
            if (sample) rx_sh_q <= {rx_sh_q[DATA_LENGTH-2:0], MISO};
            edge_cnt_q <= edge_cnt_q + 1'b1;
            if (last_edge) state_q <= ST_TRAIL;
          end
        end
        ST_TRAIL: begin
          if (tick) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            ss_n_q    <= '1;
            rx_data_q <= rx_sh_q;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign MOSI    = mosi_q;
  assign SS_n    = ss_n_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign rx_data = rx_data_q;
endmodule

// File: tb/tb_spi_master_mcs.sv
// Bench for spi_master_mcs: a default instance driven by a scoreboard with a
// behavioural SPI slave, plus a small 6-bit / 3-slave instance.
module tb_spi_master_mcs;
  localparam int DL = 8, NS = 4, DIV = 4;
  localparam int DL6 = 6, NS6 = 3, DIV6 = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic [1:0]    slave_sel = '0, mode = '0;
  logic [DL-1:0] tx_data = '0;
  logic          miso, slave_miso = 1'b0, cur_lb = 1'b0;
  logic          sck, mosi, busy, done, err;
  logic [NS-1:0] ss_n;
  logic [DL-1:0] rx_data;
  assign miso = cur_lb ? mosi : slave_miso;

  logic           start6 = 1'b0;
  logic [1:0]     sel6 = '0, mode6 = 2'd2;
  logic [DL6-1:0] tx6 = '0;
  logic           miso6, sck6, mosi6, busy6, done6, err6;
  logic [NS6-1:0] ss6;
  logic [DL6-1:0] rx6;
  assign miso6 = mosi6;

  spi_master_mcs #(.DATA_LENGTH(DL), .NUM_SLAVES(NS), .CLK_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .start(start), .slave_sel(slave_sel), .mode(mode),
    .tx_data(tx_data), .MISO(miso), .SCK(sck), .MOSI(mosi), .SS_n(ss_n),
    .busy(busy), .done(done), .err(err), .rx_data(rx_data));

  spi_master_mcs #(.DATA_LENGTH(DL6), .NUM_SLAVES(NS6), .CLK_DIV(DIV6)) dut6 (
    .clk(clk), .rst(rst), .start(start6), .slave_sel(sel6), .mode(mode6),
    .tx_data(tx6), .MISO(miso6), .SCK(sck6), .MOSI(mosi6), .SS_n(ss6),
    .busy(busy6), .done(done6), .err(err6), .rx_data(rx6));

  typedef struct {
    logic [7:0] tx, resp, rx;
    logic [1:0] sel, md;
    int         issue;
    bit         b2b, lb;
  } frame_t;

  frame_t exp_q[$];
  int     exp6_q[$];
  int     err6_q[$];
  int     n_chk = 0, n_fail = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Behavioural SPI slave for the default instance, reacting to SCK edges.
  logic [NS-1:0] ss_prev = '1;
  logic          sck_prev = 1'b0, s_cpol = 1'b0, s_cpha = 1'b0;
  logic [7:0]    s_sh = '0, cap = '0;
  int            pulses = 0, ss_hi = 0;
  always @(negedge clk) begin
    frame_t        f;
    logic          lead_e;
    logic [NS-1:0] exp_ss;
    if (ss_n != '1 && ss_prev == '1) begin
      if (exp_q.size() == 0) chk("unexpected_frame", 1, 0);
      else begin
        f = exp_q[0];
        s_cpol = f.md[1]; s_cpha = f.md[0]; cur_lb = f.lb;
        s_sh = f.resp; slave_miso = f.resp[7]; cap = '0; pulses = 0;
        exp_ss = ~(NS'(1) << f.sel);
        chk("ss_onehot", ss_n, exp_ss);
        chk("sck_idle_at_start", sck, f.md[1]);
        chk("mosi_msb_first", mosi, f.tx[7]);
        chk("busy_set", busy, 1);
        if (f.b2b) chk("ss_gap_cycles", ss_hi, 1);
      end
    end else if (ss_n != '1 && sck != sck_prev) begin
      lead_e = (sck != s_cpol);
      if (lead_e) pulses++;
      if (lead_e != s_cpha) cap = {cap[6:0], mosi};
      else if (!s_cpha) begin s_sh = s_sh << 1; slave_miso = s_sh[7]; end
      else begin slave_miso = s_sh[7]; s_sh = s_sh << 1; end
    end
    ss_hi = (ss_n == '1) ? ss_hi + 1 : 0;
    sck_prev = sck;
    ss_prev = ss_n;
  end

  // Scoreboard monitor for the default instance.
  always @(negedge clk) begin
    frame_t f;
    if (done) begin
      if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        f = exp_q.pop_front();
        chk("done_latency", cyc - f.issue, (2 * DL + 2) * DIV + 1);
        chk("rx_data", rx_data, f.rx);
        chk("slave_captured_tx", cap, f.tx);
        chk("sck_pulses", pulses, DL);
        chk("ss_release", ss_n, 4'hF);
        chk("busy_clear", busy, 0);
        chk("sck_idle_after", sck, f.md[1]);
      end
    end
    if (err) chk("unexpected_err", 1, 0);
  end

  // Monitor for the 6-bit instance: MOSI captured on leading SCK edges.
  logic [DL6-1:0] seq6 = '0;
  int             n6 = 0, exp_tx6;
  logic           sck6_prev = 1'b0, ss6_open = 1'b0;
  always @(negedge clk) begin
    if (ss6 != '1 && !ss6_open) begin
      seq6 = '0; n6 = 0; ss6_open = 1'b1;
      chk("ss6_onehot", ss6, 3'b110);
      chk("sck6_idle_at_start", sck6, mode6[1]);
    end else if (ss6 != '1 && sck6 != sck6_prev && sck6 != mode6[1]) begin
      seq6 = {seq6[DL6-2:0], mosi6};
      n6++;
    end
    if (ss6 == '1) ss6_open = 1'b0;
    sck6_prev = sck6;
    if (done6) begin
      if (exp6_q.size() == 0) chk("unexpected_done6", 1, 0);
      else begin
        chk("done6_latency", cyc - exp6_q.pop_front(), (2 * DL6 + 2) * DIV6 + 1);
        chk("mosi6_sequence", seq6, exp_tx6);
        chk("sck6_pulses", n6, DL6);
        chk("rx6_loopback", rx6, exp_tx6);
        chk("sck6_idle_after", sck6, mode6[1]);
      end
    end
    if (err6) begin
      if (err6_q.size() == 0) chk("unexpected_err6", 1, 0);
      else chk("err6_cycle", cyc, err6_q.pop_front());
    end
  end

  task automatic issue(input logic [1:0] sel, input logic [1:0] md, input logic [7:0] tx,
                       input logic [7:0] resp, input bit lb, input bit b2b);
    frame_t f;
    f.tx = tx; f.resp = resp; f.rx = lb ? tx : resp; f.sel = sel; f.md = md;
    f.issue = cyc + 1; f.b2b = b2b; f.lb = lb;
    exp_q.push_back(f);
    slave_sel = sel; mode = md; tx_data = tx; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin @(negedge clk); n++; end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_ss_n", ss_n, 4'hF);
    chk("rst_sck", sck, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done_err", {done, err}, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst6_ss_n", ss6, 3'b111);
    rst = 1'b0;
    @(negedge clk);

    // Mode 0 loopback on slave 2.
    issue(2'd2, 2'd0, 8'hA5, 8'h00, 1'b1, 1'b0);
    wait_idle();
    // Modes 1..3 against a slave answering 8'hC3.
    for (int m = 1; m < 4; m++) begin
      issue(2'(m), 2'(m), 8'h3C, 8'hC3, 1'b0, 1'b0);
      wait_idle();
    end

    // Start re-pulsed mid-frame with different inputs must be ignored.
    issue(2'd1, 2'd0, 8'h5A, 8'h81, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    tx_data = 8'hFF; slave_sel = 2'd3; mode = 2'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tx_data = 8'h00;
    wait_idle();

    // Back-to-back frames: second start presented in the done cycle.
    issue(2'd0, 2'd3, 8'h69, 8'h1E, 1'b0, 1'b0);
    n = 0;
    while (!done && n < 200) begin @(negedge clk); n++; end
    chk("b2b_done_seen", done, 1);
    issue(2'd3, 2'd1, 8'hD2, 8'h4B, 1'b0, 1'b1);
    wait_idle();

    // Randomized frames.
    for (int i = 0; i < 8; i++) begin
      issue(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 8'($urandom),
            8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      wait_idle();
    end

    // 6-bit instance: mode 2 frame, then an out-of-range select.
    @(negedge clk);
    exp_tx6 = 6'b010111;
    exp6_q.push_back(cyc + 1);
    sel6 = 2'd0; mode6 = 2'd2; tx6 = 6'b010111; start6 = 1'b1;
    @(negedge clk);
    start6 = 1'b0;
    n = 0;
    while (busy6 && n < 100) begin @(negedge clk); n++; end
    chk("busy6_finished", busy6, 0);
    @(negedge clk);
    err6_q.push_back(cyc + 1);
    sel6 = 2'd3; start6 = 1'b1;
    @(negedge clk);
    start6 = 1'b0;
    chk("err6_ss_n", ss6, 3'b111);
    chk("err6_busy", busy6, 0);
    repeat (40) @(negedge clk);
    chk("err6_ss_n_later", ss6, 3'b111);
    chk("err6_drained", err6_q.size(), 0);
    sel6 = 2'd0;

    // Reset in cycle 20 of a frame, with start held during reset.
    issue(2'd0, 2'd3, 8'h96, 8'h69, 1'b0, 1'b0);
    repeat (19) @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    exp_q.delete();
    chk("midrst_ss_n", ss_n, 4'hF);
    chk("midrst_sck", sck, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_mosi", mosi, 0);
    chk("midrst_rx_data", rx_data, 0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("start_in_rst_ignored", busy, 0);
    repeat (100) @(negedge clk);
    chk("post_rst_sck_idle", sck, 0);

    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("scoreboard6_drained", exp6_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
